seg_scan_ctrl: RTL and testbench
================================

# seg_scan_ctrl

Time-multiplexing scan controller that shares one `seven_seg` decoder among `NUM_DIGITS` common-anode digits. It holds a shadow copy of the displayed nibbles and steps through the digits at a fixed refresh rate. Each digit slot begins with a blanking gap to suppress ghosting. New values are committed only at frame boundaries. It sits between the lab top level (switch/keypad data) and the shared decoder: its `s` output drives the decoder input, and its `an` output drives the digit-enable transistors.

## Interface

Parameters:
- `NUM_DIGITS`, 2: number of multiplexed digits; must be ≥ 2.
- `CYCLES_PER_DIGIT`, 24000: clock cycles per digit slot, blanking included.
- `BLANK_CYCLES`, 200: cycles at the start of each slot with all digits off; 1 ≤ `BLANK_CYCLES` < `CYCLES_PER_DIGIT`.

Ports:
- `clk`  in  1  system clock.
- `reset`  in  1  asynchronous, active-high reset.
- `load`  in  1  single-cycle strobe that captures `digits_in` into staging.
- `digits_in`  in  4*NUM_DIGITS  nibble i occupies bits [4i+3:4i]; digit 0 is scanned first.
- `s`  out  4  nibble for the shared `seven_seg` decoder.
- `an`  out  NUM_DIGITS  active-low digit enables; at most one bit is low.
- `pending`  out  1  staging holds data not yet committed to display.
- `frame_start`  out  1  one-cycle pulse at each frame boundary.

## Operation

- **State**
  - `cnt`: 0..CYCLES_PER_DIGIT-1.
  - `idx`: 0..NUM_DIGITS-1.
  - `active[]`: displayed nibbles.
  - `staging[]`: captured nibbles.
  - `pending` flag.
- **Outputs:** all outputs come directly from flops (Moore); there is no combinational path from inputs to outputs.
- **Slot phases:** two phases per slot, decoded from `cnt`.
  - BLANK: `cnt` < `BLANK_CYCLES`. `an` = all ones.
  - ON: `cnt` ≥ `BLANK_CYCLES`. `an` = ~(1 << idx).
- **Each clock edge:** `cnt` increments. At `cnt` == `CYCLES_PER_DIGIT`-1 the following happen:
  - `cnt` wraps to 0.
  - `idx` advances modulo `NUM_DIGITS`.
  - `an` returns to all ones.
  - `s` loads the nibble for the new `idx`.
- **Frame boundary:** the slot-end edge where `idx` wraps from `NUM_DIGITS`-1 to 0.
  - If `pending` = 1: `active` ← `staging`, `pending` ← 0, and `s` ← `staging[0]`.
  - If `pending` = 0: `active` is unchanged.
  - `frame_start` is 1 for the cycle following the boundary edge, and 0 otherwise.
- **`s` stability:** `s` changes only at slot-end edges, so the decoder settles while all digits are blanked.
- **Load behaviour:** on `load` = 1, `staging` ← `digits_in` and `pending` ← 1.
  - A second load before the boundary overwrites `staging`; only the last value is displayed.
  - `load` held high for several cycles captures every cycle; the final cycle's data wins.
- **Load coincident with boundary edge**
  - The commit uses the pre-edge `staging`, if `pending` was 1.
  - The new `digits_in` goes into `staging`, and `pending` is 1 after the edge.
  - The new value is displayed one frame later.
- **Reset** (asynchronous; takes effect immediately, including mid-slot):
  - `an` = all ones, `s` = 0, `pending` = 0, `frame_start` = 0.
  - `cnt` = 0, `idx` = 0, `active` = 0, `staging` = 0.
- **After reset deassertion:** the first edge starts digit 0 BLANK at `cnt` = 1. No `frame_start` pulse is generated on reset exit.
- **Counter width:** `cnt` is $clog2(CYCLES_PER_DIGIT) bits and `idx` is $clog2(NUM_DIGITS) bits. Neither may wrap except at the defined terminal counts, including for non-power-of-two `NUM_DIGITS`.

## Timing

- Slot length = `CYCLES_PER_DIGIT` cycles; frame length = `NUM_DIGITS`·`CYCLES_PER_DIGIT` cycles.
- ON duration per digit per frame = `CYCLES_PER_DIGIT` − `BLANK_CYCLES` cycles.
- Enable transitions:
  - `an` falls on the edge where `cnt` goes from `BLANK_CYCLES`-1 to `BLANK_CYCLES`.
  - `an` rises on the slot-end edge.
- Load to `pending` high: 1 edge.
- Load to displayed (worst case): 1 frame plus 1 slot BLANK.
- `frame_start` period = one frame length.
- Defaults at 24 MHz give a 1 ms slot and a 500 Hz frame.

## Test plan

Bench parameters: `NUM_DIGITS`=2, `CYCLES_PER_DIGIT`=8, `BLANK_CYCLES`=2; `seven_seg` instantiated on `s`.

1. **Asynchronous reset:** assert `reset` mid-ON between clock edges -> `an`=2'b11, `s`=0, `pending`=0 and `frame_start`=0 immediately, without a clock edge.
2. **Load 8'h3A after reset** -> `pending`=1 after 1 edge; commit at the first boundary (`frame_start` pulses, `pending`=0). Then:
   - Digit 0: `s`=4'hA, `an`=2'b11 for 2 cycles, then 2'b10 for 6 cycles.
   - Digit 1: `s`=4'h3, `an`=2'b11 for 2 cycles, then 2'b01 for 6 cycles.
3. **Overwrite:** load 8'h12, then load 8'h45 before the boundary -> after commit, digits show 5 (digit 0) and 4 (digit 1); 8'h12 never appears on `s`.
4. **Load on boundary edge:** with `pending`=1 holding 8'h77, load 8'h99 on the boundary edge -> 7s are displayed for the next frame and `pending` stays 1; 9s are committed at the following `frame_start`.
5. **Exclusion and cadence over 100 frames:**
   - `an` never has more than one zero.
   - Each digit is enabled exactly 6 cycles per frame.
   - `frame_start` pulses every 16 cycles.
   - `s` changes only while `an`=2'b11.

Source files
------------

// File: rtl/seg_scan_ctrl.sv
// seg_scan_ctrl: time-multiplexed scan controller for NUM_DIGITS common-anode
// seven-segment digits that share one decoder.
//
// Each digit slot lasts CYCLES_PER_DIGIT clocks. The first BLANK_CYCLES clocks
// of every slot keep all anodes off so the shared decoder can settle without
// ghosting. Digit values are captured into a staging copy on 'load' and are
// only committed to the displayed copy at a frame boundary, which is the end
// of the last digit's slot.
//
// Ports:
//   clk          system clock
//   reset        asynchronous, active-high reset
//   load         single-cycle strobe: capture digits_in into staging
//   digits_in    nibble i at [4i+3:4i]; digit 0 is scanned first
//   s            nibble driving the shared seven_seg decoder
//   an           active-low digit enables, at most one low
//   pending      staging holds data not yet shown
//   frame_start  one-cycle pulse after each frame boundary edge
//
// All outputs are registered; there is no input-to-output combinational path.

module seg_scan_ctrl #(
    parameter int unsigned NUM_DIGITS       = 2,
    parameter int unsigned CYCLES_PER_DIGIT = 24000,
    parameter int unsigned BLANK_CYCLES     = 200
) (
    input  logic                    clk,
    input  logic                    reset,
    input  logic                    load,
    input  logic [4*NUM_DIGITS-1:0] digits_in,
    output logic [3:0]              s,
    output logic [NUM_DIGITS-1:0]   an,
    output logic                    pending,
    output logic                    frame_start
);

    localparam int unsigned CntW = $clog2(CYCLES_PER_DIGIT);
    localparam int unsigned IdxW = $clog2(NUM_DIGITS);

    logic [CntW-1:0]         cnt_q, cnt_d;
    logic [IdxW-1:0]         idx_q, idx_d;
    logic [4*NUM_DIGITS-1:0] active_q, active_d;
    logic [4*NUM_DIGITS-1:0] staging_q, staging_d;
    logic                    pending_d;
    logic [3:0]              s_d;
    logic [NUM_DIGITS-1:0]   an_d;
    logic                    frame_start_d;

    logic slot_end;
    logic boundary;

    assign slot_end = (cnt_q == CntW'(CYCLES_PER_DIGIT - 1));
    assign boundary = slot_end && (idx_q == IdxW'(NUM_DIGITS - 1));

    always_comb begin
        cnt_d = slot_end ? '0 : cnt_q + 1'b1;

        // Explicit wrap keeps non-power-of-two digit counts in range.
        idx_d = idx_q;
        if (slot_end) begin
            idx_d = boundary ? '0 : idx_q + 1'b1;
        end

        // Commit uses the pre-edge staging; a coincident load lands in
        // staging and stays pending for the next frame.
        active_d  = (boundary && pending) ? staging_q : active_q;
        staging_d = load ? digits_in : staging_q;
        pending_d = load | (pending & ~boundary);

        // Enables are decoded from the next count so 'an' is a pure flop.
        an_d = '1;
        if (cnt_d >= CntW'(BLANK_CYCLES)) begin
            an_d[idx_d] = 1'b0;
        end

        // 's' only moves at slot ends, i.e. while every digit is blanked.
        // At a committing boundary active_d already holds the new staging.
        s_d = s;
        if (slot_end) begin
            s_d = active_d[idx_d*4 +: 4];
        end

        frame_start_d = boundary;
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            cnt_q       <= '0;
            idx_q       <= '0;
            active_q    <= '0;
            staging_q   <= '0;
            pending     <= 1'b0;
            s           <= 4'h0;
            an          <= '1;
            frame_start <= 1'b0;
        end else begin
            cnt_q       <= cnt_d;
            idx_q       <= idx_d;
            active_q    <= active_d;
            staging_q   <= staging_d;
            pending     <= pending_d;
            s           <= s_d;
            an          <= an_d;
            frame_start <= frame_start_d;
        end
    end

endmodule

// File: tb/tb_seg_scan_ctrl.sv
// Self-checking bench for seg_scan_ctrl (2 digits, 8-cycle slots, 2 blanking
// cycles). A reference model derives the expected outputs from the number of
// clock edges since reset plus a staging/active copy updated at frame
// boundaries; a table and several directed sequences pin down the corner cases.

module tb_seg_scan_ctrl;

    localparam int N = 2;
    localparam int C = 8;
    localparam int B = 2;
    localparam int F = N * C;

    logic       clk = 1'b0;
    logic       reset;
    logic       load;
    logic [7:0] digits_in;
    logic [3:0] s;
    logic [1:0] an;
    logic       pending;
    logic       frame_start;

    always #5 clk = ~clk;

    seg_scan_ctrl #(
        .NUM_DIGITS      (N),
        .CYCLES_PER_DIGIT(C),
        .BLANK_CYCLES    (B)
    ) dut (
        .clk        (clk),
        .reset      (reset),
        .load       (load),
        .digits_in  (digits_in),
        .s          (s),
        .an         (an),
        .pending    (pending),
        .frame_start(frame_start)
    );

    int checks = 0;
    int errors = 0;

    // Reference model state
    int         t;
    logic [3:0] m_act [N];
    logic [3:0] m_stg [N];
    bit         m_pend;
    logic [3:0] prev_s;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h (t=%0d, time %0t)", name, act, exp, t, $time);
        end
    endtask

    task automatic model_reset();
        t = 0;
        m_pend = 1'b0;
        for (int i = 0; i < N; i++) begin
            m_act[i] = 4'h0;
            m_stg[i] = 4'h0;
        end
        prev_s = 4'h0;
    endtask

    // Apply one cycle of inputs, advance the model by one edge, then compare.
    task automatic step(input logic ld, input logic [7:0] din);
        int         cnt;
        int         idx;
        logic [1:0] e_an;
        load      = ld;
        digits_in = din;
        @(posedge clk);
        t++;
        if ((t % F == 0) && m_pend) begin
            for (int i = 0; i < N; i++) m_act[i] = m_stg[i];
            m_pend = 1'b0;
        end
        if (ld) begin
            for (int i = 0; i < N; i++) m_stg[i] = din[4*i +: 4];
            m_pend = 1'b1;
        end
        #1;
        cnt  = t % C;
        idx  = (t / C) % N;
        e_an = 2'b11;
        if (cnt >= B) e_an[idx] = 1'b0;
        chk("model_an", an, e_an);
        chk("model_s", s, m_act[idx]);
        chk("model_pending", pending, m_pend);
        chk("model_frame_start", frame_start, (t % F == 0));
        chk("an_at_most_one_low", ($countones(~an) <= 1), 1);
        if (s !== prev_s) chk("s_change_while_blanked", an, 2'b11);
        prev_s = s;
        load = 1'b0;
    endtask

    typedef struct {
        logic       ld;
        logic [7:0] din;
        int         reps;
        logic [3:0] s;
        logic [1:0] an;
        logic       pend;
        logic       fs;
    } vec_t;

    vec_t tbl [10];
    int   on_cnt [N];
    int   since_fs;
    bit   started;
    bit   seen12;

    initial begin
        // Load 8'h3A right after reset, then walk two full frames.
        tbl[0] = '{1'b1, 8'h3A, 1, 4'h0, 2'b11, 1'b1, 1'b0};
        tbl[1] = '{1'b0, 8'h00, 6, 4'h0, 2'b10, 1'b1, 1'b0};
        tbl[2] = '{1'b0, 8'h00, 2, 4'h0, 2'b11, 1'b1, 1'b0};
        tbl[3] = '{1'b0, 8'h00, 6, 4'h0, 2'b01, 1'b1, 1'b0};
        tbl[4] = '{1'b0, 8'h00, 1, 4'hA, 2'b11, 1'b0, 1'b1};
        tbl[5] = '{1'b0, 8'h00, 1, 4'hA, 2'b11, 1'b0, 1'b0};
        tbl[6] = '{1'b0, 8'h00, 6, 4'hA, 2'b10, 1'b0, 1'b0};
        tbl[7] = '{1'b0, 8'h00, 2, 4'h3, 2'b11, 1'b0, 1'b0};
        tbl[8] = '{1'b0, 8'h00, 6, 4'h3, 2'b01, 1'b0, 1'b0};
        tbl[9] = '{1'b0, 8'h00, 1, 4'hA, 2'b11, 1'b0, 1'b1};

        reset     = 1'b1;
        load      = 1'b0;
        digits_in = 8'h00;
        model_reset();
        #1;
        chk("rst_an", an, 2'b11);
        chk("rst_s", s, 4'h0);
        chk("rst_pending", pending, 1'b0);
        chk("rst_frame_start", frame_start, 1'b0);
        repeat (2) @(negedge clk);
        reset = 1'b0;

        // Table-driven first frames after reset
        for (int k = 0; k < 10; k++) begin
            for (int r = 0; r < tbl[k].reps; r++) begin
                step(tbl[k].ld, tbl[k].din);
                chk($sformatf("tbl%0d_s", k), s, tbl[k].s);
                chk($sformatf("tbl%0d_an", k), an, tbl[k].an);
                chk($sformatf("tbl%0d_pending", k), pending, tbl[k].pend);
                chk($sformatf("tbl%0d_frame_start", k), frame_start, tbl[k].fs);
            end
        end

        // Asynchronous reset mid-ON, between edges
        step(1'b1, 8'h55);
        step(1'b0, 8'h00);
        chk("pre_async_an", an, 2'b10);
        #2;
        reset = 1'b1;
        #1;
        chk("async_rst_an", an, 2'b11);
        chk("async_rst_s", s, 4'h0);
        chk("async_rst_pending", pending, 1'b0);
        chk("async_rst_frame_start", frame_start, 1'b0);
        model_reset();
        repeat (2) @(negedge clk);
        reset = 1'b0;

        // Overwrite before the boundary: only 8'h45 may appear
        seen12 = 1'b0;
        step(1'b1, 8'h12);
        chk("ovw_pending", pending, 1'b1);
        repeat (3) step(1'b0, 8'h00);
        step(1'b1, 8'h45);
        while (t < 48) begin
            step(1'b0, 8'h00);
            if (s == 4'h1 || s == 4'h2) seen12 = 1'b1;
            if (t == 16) chk("ovw_digit0", s, 4'h5);
            if (t == 24) chk("ovw_digit1", s, 4'h4);
        end
        chk("ovw_never_12", seen12, 1'b0);

        // Load coincident with the boundary edge
        step(1'b1, 8'h77);
        while (t % F != F - 1) step(1'b0, 8'h00);
        step(1'b1, 8'h99);
        chk("bnd_s", s, 4'h7);
        chk("bnd_pending", pending, 1'b1);
        chk("bnd_frame_start", frame_start, 1'b1);
        while (t % F != C) step(1'b0, 8'h00);
        chk("bnd_digit1", s, 4'h7);
        while (t % F != 0) step(1'b0, 8'h00);
        chk("bnd_next_s", s, 4'h9);
        chk("bnd_next_pending", pending, 1'b0);
        chk("bnd_next_frame_start", frame_start, 1'b1);

        // Random loads over 100 frames with cadence checks
        started  = 1'b0;
        since_fs = 0;
        for (int i = 0; i < N; i++) on_cnt[i] = 0;
        for (int k = 0; k < 100 * F; k++) begin
            step(($urandom_range(0, 19) == 0), 8'($urandom));
            if (frame_start) begin
                if (started) begin
                    for (int i = 0; i < N; i++)
                        chk($sformatf("on_cycles_d%0d", i), on_cnt[i], C - B);
                    chk("frame_start_period", since_fs, F);
                end
                started  = 1'b1;
                since_fs = 0;
                for (int i = 0; i < N; i++) on_cnt[i] = 0;
            end
            if (started) begin
                since_fs++;
                for (int i = 0; i < N; i++) if (an[i] == 1'b0) on_cnt[i]++;
            end
        end
        chk("random_saw_frames", started, 1'b1);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
